// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] R0 = '0;

    // The EX stage takes RW from this value when it is loaded with a bubble.
    localparam logic NOP_RW = 1'b0;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_t;

    // A register write in flight: write-enable plus destination index.
    typedef struct packed {
        logic             rw;
        logic [REG_W-1:0] da;
    } wr_tag_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Tracks register writes sitting in EX and WB and flags DOF operand reads that collide with them.
module hz_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dof_valid,
    input  logic             dof_rw,
    input  logic [REG_W-1:0] dof_da,
    input  logic [REG_W-1:0] dof_aa,
    input  logic [REG_W-1:0] dof_ba,
    input  logic             dof_ma,
    input  logic             dof_mb,
    output logic             hazard_c
);

    wr_tag_t ex_q;
    wr_tag_t wb_q;
    logic    use_a;
    logic    use_b;
    logic    match_a;
    logic    match_b;

    // Nothing is readable until the cycle after WB, so both EX and WB entries block.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '{rw: 1'b0, da: R0};
            wb_q <= '{rw: 1'b0, da: R0};
        end else begin
            wb_q <= ex_q;
            if (load) begin
                ex_q <= '{rw: dof_rw & dof_valid, da: dof_da};
            end else begin
                ex_q.rw <= NOP_RW;
            end
        end
    end

    // R0 reads never wait; PC / constant operands do not read the register file.
    assign use_a   = dof_valid & ~dof_ma & (dof_aa != R0);
    assign use_b   = dof_valid & ~dof_mb & (dof_ba != R0);
    assign match_a = (ex_q.rw & (ex_q.da == dof_aa)) | (wb_q.rw & (wb_q.da == dof_aa));
    assign match_b = (ex_q.rw & (ex_q.da == dof_ba)) | (wb_q.rw & (wb_q.da == dof_ba));

    assign hazard_c = (use_a & match_a) | (use_b & match_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller for the IF/DOF/EX/WB pipeline, with saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             dof_valid,
    input  logic             dof_rw,
    input  logic [REG_W-1:0] dof_da,
    input  logic [REG_W-1:0] dof_aa,
    input  logic [REG_W-1:0] dof_ba,
    input  logic             dof_ma,
    input  logic             dof_mb,
    input  logic             ex_branch_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam int unsigned      FC_W       = 3;
    localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    hz_state_t       state;
    hz_state_t       state_nxt;
    logic [FC_W-1:0] fcnt;
    logic [FC_W-1:0] fcnt_nxt;
    logic            hazard_c;

    hz_scoreboard u_scoreboard (
        .clk       (CLK),
        .reset     (RESET),
        .load      (~bubble_ex),
        .dof_valid (dof_valid),
        .dof_rw    (dof_rw),
        .dof_da    (dof_da),
        .dof_aa    (dof_aa),
        .dof_ba    (dof_ba),
        .dof_ma    (dof_ma),
        .dof_mb    (dof_mb),
        .hazard_c  (hazard_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= HZ_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // A taken branch overrides everything; in FLUSH the DOF word is wrong-path so hazards are ignored.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        if (ex_branch_taken) begin
            flush     = 1'b1;
            bubble_ex = 1'b1;
            fcnt_nxt  = FLUSH_LOAD;
            state_nxt = (FLUSH_LOAD != '0) ? HZ_FLUSH : HZ_RUN;
        end else begin
            case (state)
                HZ_FLUSH: begin
                    flush     = 1'b1;
                    bubble_ex = 1'b1;
                    fcnt_nxt  = (fcnt != '0) ? fcnt - FC_W'(1) : '0;
                    if (fcnt <= FC_W'(1)) begin
                        state_nxt = HZ_RUN;
                    end
                end
                default: begin
                    if (hazard_c) begin
                        stall_if  = 1'b1;
                        bubble_ex = 1'b1;
                        state_nxt = HZ_STALL;
                    end else begin
                        state_nxt = HZ_RUN;
                    end
                end
            endcase
        end
        if (RESET) begin
            stall_if  = 1'b0;
            bubble_ex = 1'b0;
            flush     = 1'b0;
        end
    end

    assign hz_state = RESET ? HZ_RUN : state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (stall_if && (perf_stalls != CNT_MAX)) begin
                perf_stalls <= perf_stalls + CNT_W'(1);
            end
            if (ex_branch_taken && (perf_flushes != CNT_MAX)) begin
                perf_flushes <= perf_flushes + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus a randomized run against a timing model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FLUSH_LEN = 2;
    localparam int unsigned CNT_W     = 6;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             dof_valid;
    logic             dof_rw;
    logic [4:0]       dof_da;
    logic [4:0]       dof_aa;
    logic [4:0]       dof_ba;
    logic             dof_ma;
    logic             dof_mb;
    logic             ex_branch_taken;
    logic             stall_if;
    logic             bubble_ex;
    logic             flush;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] perf_stalls;
    logic [CNT_W-1:0] perf_flushes;

    pipe_hazard_ctrl #(.FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .dof_valid       (dof_valid),
        .dof_rw          (dof_rw),
        .dof_da          (dof_da),
        .dof_aa          (dof_aa),
        .dof_ba          (dof_ba),
        .dof_ma          (dof_ma),
        .dof_mb          (dof_mb),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .flush           (flush),
        .hz_state        (hz_state),
        .perf_stalls     (perf_stalls),
        .perf_flushes    (perf_flushes)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a register written by an instruction issued in cycle c is unreadable in DOF until c+3.
    longint cyc = 0;
    longint busy [32];
    int     flush_left = 0;
    bit     in_stall = 0;
    int     m_stalls = 0;
    int     m_flushes = 0;
    bit     check_on = 0;
    bit     exp_stall = 0;
    bit     exp_bubble = 0;
    bit     exp_flush = 0;
    int     exp_state = 0;
    int     stall_run = 0;
    bit     ua, ub, hz;

    always @(negedge CLK) begin
        if (check_on) begin
            ua = dof_valid && !dof_ma && (dof_aa != 0);
            ub = dof_valid && !dof_mb && (dof_ba != 0);
            hz = (ua && busy[dof_aa] >= cyc) || (ub && busy[dof_ba] >= cyc);
            exp_stall  = 0;
            exp_bubble = 0;
            exp_flush  = 0;
            exp_state  = 0;
            if (!RESET) begin
                exp_state = (flush_left > 0) ? 2 : (in_stall ? 1 : 0);
                if (ex_branch_taken) begin
                    exp_flush  = 1;
                    exp_bubble = 1;
                end else if (flush_left > 0) begin
                    exp_flush  = 1;
                    exp_bubble = 1;
                end else if (hz) begin
                    exp_stall  = 1;
                    exp_bubble = 1;
                end
            end
            chk("stall_if", 32'(stall_if), 32'(exp_stall));
            chk("bubble_ex", 32'(bubble_ex), 32'(exp_bubble));
            chk("flush", 32'(flush), 32'(exp_flush));
            chk("hz_state", 32'(hz_state), 32'(exp_state));
            chk("perf_stalls", 32'(perf_stalls), 32'(m_stalls));
            chk("perf_flushes", 32'(perf_flushes), 32'(m_flushes));
            chk("stall_flush_excl", 32'(stall_if & flush), 32'd0);
            stall_run = (stall_if === 1'b1) ? stall_run + 1 : 0;
            chk("stall_run_le2", 32'(stall_run > 2), 32'd0);
        end
    end

    always @(posedge CLK) begin
        if (check_on) begin
            if (RESET) begin
                foreach (busy[i]) busy[i] = -1;
                flush_left = 0;
                in_stall   = 0;
                m_stalls   = 0;
                m_flushes  = 0;
            end else begin
                if (ex_branch_taken) flush_left = FLUSH_LEN - 1;
                else if (flush_left > 0) flush_left--;
                in_stall = exp_stall;
                if (exp_stall && m_stalls < CNT_MAX) m_stalls++;
                if (ex_branch_taken && m_flushes < CNT_MAX) m_flushes++;
                if (!exp_bubble && dof_valid && dof_rw && dof_da != 0) busy[dof_da] = cyc + 2;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ins(input bit v, input bit rw, input int da, input int aa, input int ba,
                       input bit ma, input bit mb, input bit br);
        dof_valid       = v;
        dof_rw          = rw;
        dof_da          = 5'(da);
        dof_aa          = 5'(aa);
        dof_ba          = 5'(ba);
        dof_ma          = ma;
        dof_mb          = mb;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        nop();
        @(negedge CLK);
        chk({tag, "_rst_stall"}, 32'(stall_if), 32'd0);
        chk({tag, "_rst_flush"}, 32'(flush), 32'd0);
        chk({tag, "_rst_state"}, 32'(hz_state), 32'd0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk({tag, "_rst_pstall"}, 32'(perf_stalls), 32'd0);
        chk({tag, "_rst_pflush"}, 32'(perf_flushes), 32'd0);
        tick();
    endtask

    initial begin
        foreach (busy[i]) busy[i] = -1;
        RESET = 1'b1;
        nop();
        tick();
        check_on = 1;
        do_reset("init");

        // Back-to-back RAW on R3: two stall cycles, then release.
        ins(1, 1, 3, 1, 2, 0, 0, 0); @(negedge CLK); chk("t1_add", 32'(stall_if), 0); tick();
        ins(1, 1, 4, 3, 0, 0, 1, 0); @(negedge CLK);
        chk("t1_stall1", 32'(stall_if), 1); chk("t1_bub1", 32'(bubble_ex), 1); tick();
        @(negedge CLK);
        chk("t1_stall2", 32'(stall_if), 1); chk("t1_bub2", 32'(bubble_ex), 1);
        chk("t1_state", 32'(hz_state), 1); tick();
        @(negedge CLK);
        chk("t1_release", 32'(stall_if), 0); chk("t1_pstall", 32'(perf_stalls), 2); tick();
        nop(); @(negedge CLK); chk("t1_run", 32'(hz_state), 0); tick();

        // R0 is never a hazard.
        ins(1, 1, 0, 1, 1, 0, 0, 0); tick();
        ins(1, 1, 6, 0, 0, 0, 0, 0); @(negedge CLK); chk("t2_r0", 32'(stall_if), 0); tick();
        nop(); tick(); tick();

        // Constant B operand ignores BA; register B operand stalls.
        ins(1, 1, 5, 0, 0, 0, 0, 0); tick();
        ins(1, 1, 6, 0, 5, 0, 1, 0); @(negedge CLK); chk("t3_mb1", 32'(stall_if), 0); tick();
        nop(); tick(); tick();
        ins(1, 1, 5, 0, 0, 0, 0, 0); tick();
        ins(1, 1, 7, 0, 5, 0, 0, 0); @(negedge CLK); chk("t3_mb0", 32'(stall_if), 1); tick();
        tick();
        nop(); tick();

        // Taken branch beats a pending hazard.
        do_reset("t4");
        ins(1, 1, 3, 0, 0, 0, 0, 0); tick();
        ins(1, 1, 4, 3, 0, 0, 1, 1); @(negedge CLK);
        chk("t4_flush1", 32'(flush), 1); chk("t4_nostall1", 32'(stall_if), 0); tick();
        ins(1, 1, 4, 3, 0, 0, 1, 0); @(negedge CLK);
        chk("t4_flush2", 32'(flush), 1); chk("t4_nostall2", 32'(stall_if), 0);
        chk("t4_state", 32'(hz_state), 2); tick();
        @(negedge CLK);
        chk("t4_done", 32'(flush), 0); chk("t4_pflush", 32'(perf_flushes), 1);
        chk("t4_pstall", 32'(perf_stalls), 0); tick();
        nop(); tick();

        // Reset in the middle of a flush aborts it.
        do_reset("t6");
        ins(1, 1, 3, 0, 0, 0, 0, 0); tick();
        ins(0, 0, 0, 0, 0, 0, 0, 1); @(negedge CLK); chk("t6_flush1", 32'(flush), 1); tick();
        nop(); RESET = 1'b1; @(negedge CLK);
        chk("t6_rst_flush", 32'(flush), 0); chk("t6_rst_state", 32'(hz_state), 0); tick();
        RESET = 1'b0;
        ins(1, 1, 4, 3, 0, 0, 1, 0); @(negedge CLK);
        chk("t6_state", 32'(hz_state), 0); chk("t6_flush", 32'(flush), 0);
        chk("t6_stall", 32'(stall_if), 0); chk("t6_pflush", 32'(perf_flushes), 0); tick();
        // Reset must empty the scoreboard: the R3 write would otherwise still be in WB.
        ins(1, 1, 3, 0, 0, 0, 0, 0); tick();
        nop(); RESET = 1'b1; tick();
        RESET = 1'b0;
        ins(1, 1, 4, 3, 0, 0, 1, 0); @(negedge CLK); chk("t6_sb_empty", 32'(stall_if), 0); tick();

        // Every instruction hazards on its predecessor: perf_stalls must saturate.
        do_reset("t5");
        ins(1, 1, 3, 3, 0, 0, 1, 0);
        repeat (110) tick();
        @(negedge CLK); chk("t5_sat", 32'(perf_stalls), 32'(CNT_MAX)); tick();
        @(negedge CLK); chk("t5_sat_hold", 32'(perf_stalls), 32'(CNT_MAX)); tick();

        // Randomized traffic; DOF is held while the model says IF/DOF are stalled.
        do_reset("rnd");
        for (int n = 0; n < 3000; n++) begin
            if (!exp_stall) begin
                ins(($urandom % 8) != 0, $urandom % 2, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), ($urandom % 4) == 0, ($urandom % 4) == 0, 0);
            end
            ex_branch_taken = ($urandom % 10) == 0;
            RESET = ($urandom % 150) == 0;
            tick();
        end
        RESET = 1'b0;
        nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and flush controller for the 4-stage RISC pipeline: IF, DOF (decode/operand fetch), EX, WB.
- Consumes the decoder's control word (RW, DA, AA, BA, MA, MB, BS) for the instruction in DOF, plus the branch resolution from EX.
- Tracks in-flight register writes and generates PC/IR hold, EX bubble insertion and wrong-path flush.
- Keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_LEN, 2, cycles flush stays asserted per taken branch/jump (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- dof_valid  in  1  DOF holds a real instruction
- dof_rw  in  1  decoder RW
- dof_da  in  5  decoder DA
- dof_aa  in  5  decoder AA
- dof_ba  in  5  decoder BA
- dof_ma  in  1  decoder MA (1 = A operand is PC, AA unused)
- dof_mb  in  1  decoder MB (1 = B operand is constant, BA unused)
- ex_branch_taken  in  1  EX resolved BZ/BNZ taken, or JMR/JMP/JML
- stall_if  out  1  hold PC and IR this cycle
- bubble_ex  out  1  load NOP into EX (RW=0, MW=0, BS=00) instead of the DOF word
- flush  out  1  replace IF and DOF contents with NOP at the next edge
- hz_state  out  2  FSM state, for debug
- perf_stalls  out  CNT_W  stall-cycle count, saturating
- perf_flushes  out  CNT_W  taken-branch count, saturating

Behaviour:
- Register file timing: writes in WB; a value is readable in DOF the cycle after WB. No bypass exists.
- R0 is hardwired zero. DA/AA/BA = 0 never create a hazard.
- Scoreboard: ex_rw/ex_da and wb_rw/wb_da registers. Every cycle wb <= ex.
  - ex <= {dof_rw & dof_valid, dof_da} when no bubble and no flush.
  - Otherwise ex_rw <= 0.
- Operand use:
  - use_a = dof_valid & ~dof_ma & (dof_aa != 0)
  - use_b = dof_valid & ~dof_mb & (dof_ba != 0)
- hazard = (use_a & match(aa)) | (use_b & match(ba)), where match(r) = (ex_rw & ex_da==r) | (wb_rw & wb_da==r).
- FSM states: RUN=0, STALL=1, FLUSH=2.
  - RUN:
    - ex_branch_taken -> flush=1, bubble_ex=1, load flush counter with FLUSH_LEN-1; go to FLUSH if FLUSH_LEN>1, else stay in RUN.
    - else hazard -> stall_if=1, bubble_ex=1, go to STALL.
    - else all outputs 0.
  - STALL: hazard is re-evaluated every cycle.
    - Still true -> stall_if=1, bubble_ex=1.
    - False -> outputs 0, go to RUN.
    - Maximum 2 consecutive stall cycles; more indicates a bug. The bench checks this.
  - FLUSH: flush=1, bubble_ex=1, counter decrements; at 0 go to RUN. Hazard is ignored, since the DOF content is wrong-path.
- Priority: ex_branch_taken beats hazard in every state. A taken branch in STALL goes straight to the RUN branch action.
- stall_if and flush are never both 1.
- perf_stalls increments on each cycle with stall_if=1; perf_flushes increments on each ex_branch_taken cycle. Both saturate at all-ones.
- All outputs are combinational from state, scoreboard and inputs; no added latency.
- RESET: state RUN, scoreboard rw bits 0, flush counter 0, counters 0.
  - Outputs during and after reset: stall_if=0, bubble_ex=0, flush=0, hz_state=0.
  - RESET mid-STALL or mid-FLUSH aborts to RUN on the same edge.

Decomposition:
- Shared package: state encodings (HZ_RUN, HZ_STALL, HZ_FLUSH), NOP control-word constants, register index width (5), R0 index.
- Sub-module: hz_scoreboard (ex/wb rw+da pipeline plus match logic). The FSM and counters stay in the top module.

Test Plan:
- ADD R3 in DOF followed next cycle by SUB reading AA=3 -> stall_if=1 for 2 cycles, bubble_ex=1 both cycles, perf_stalls=2, then RUN.
- Write R0 followed by a read of R0 -> no stall; stall_if stays 0.
- ADI (MB=1) with BA=5 while EX writes R5 -> no stall. Same with MB=0 -> stall.
- ex_branch_taken pulse while a hazard is present -> flush=1 for 2 cycles, stall_if=0, perf_flushes=1, perf_stalls unchanged.
- Inject a hazard on every instruction with perf_stalls at all-ones -> value holds at all-ones.
- Assert RESET during FLUSH cycle 1 -> next cycle hz_state=0, flush=0, counters=0, scoreboard empty (read of the prior DA gives no stall).
